// File: rtl/scan_chain_pkg.sv
// Shared state encoding and counter sizing for the scan chain controller.
package scan_chain_pkg;

    localparam int DEF_NUM_IOS = 8;
    localparam int MAX_DESIGNS = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_LATCH,
        ST_CAPTURE,
        ST_SHIFT_OUT,
        ST_DONE
    } scan_state_e;

    // Bit counter wide enough to index any chain position of the largest chain.
    function automatic int cnt_width(input int num_ios);
        return $clog2(MAX_DESIGNS * num_ios);
    endfunction

    localparam int BIT_CNT_W = cnt_width(DEF_NUM_IOS);

endpackage

// File: rtl/scan_phase_gen.sv
// Bit/phase sequencer: two clk per scan bit, scan_clk high in phase 1 of pulsing states.
module scan_phase_gen
    import scan_chain_pkg::*;
#(
    parameter int CNT_W = BIT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart_i,
    input  logic             pulse_en_i,
    output logic [CNT_W-1:0] bit_o,
    output logic [CNT_W-1:0] bit_nxt_o,
    output logic             phase_o,
    output logic             scan_clk_o
);

    logic [CNT_W-1:0] bit_q, bit_d;
    logic             phase_q, phase_d;
    logic             scan_clk_q, scan_clk_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        bit_d   = bit_q;
        phase_d = ~phase_q;
        if (restart_i) begin
            bit_d   = '0;
            phase_d = 1'b0;
        end else if (phase_q) begin
            bit_d = bit_q + CNT_W'(1);
        end
        scan_clk_d = pulse_en_i & phase_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state uses non-blocking assignments so all flops see pre-edge values.
        if (reset) begin
            bit_q      <= '0;
            phase_q    <= 1'b0;
            scan_clk_q <= 1'b0;
        end else begin
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            scan_clk_q <= scan_clk_d;
        end
    end

    assign bit_o      = bit_q;
    assign bit_nxt_o  = bit_d;
    assign phase_o    = phase_q;
    assign scan_clk_o = scan_clk_q;

endmodule

// File: rtl/scan_chain_controller.sv
// Scan chain controller: drives one design per frame and reads its outputs back.
// Optional SCAN_SELECT_RANGE_CHECK_EN: out-of-range active_select shifts zeros and returns 0.
module scan_chain_controller
    import scan_chain_pkg::*;
#(
    parameter int NUM_DESIGNS = 4,
    parameter int NUM_IOS     = DEF_NUM_IOS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8:0]         active_select,
    input  logic [NUM_IOS-1:0] inputs,
    output logic [NUM_IOS-1:0] outputs,
    output logic               ready,
    output logic               scan_clk,
    output logic               scan_data_out,
    input  logic               scan_data_in,
    output logic               scan_select,
    output logic               scan_latch_enable
);

    localparam int L     = NUM_DESIGNS * NUM_IOS;
    localparam int CNT_W = cnt_width(NUM_IOS);
    localparam int POS_W = CNT_W + 1;
    localparam int SEL_W = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1;
    localparam int IO_W  = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(L - 1);

    scan_state_e        state_q, state_d;
    logic [NUM_IOS-1:0] in_q, in_d;
    logic [POS_W-1:0]   base_q, base_d;
    logic               valid_q, valid_d;
    logic [NUM_IOS-1:0] shadow_q, shadow_d;
    logic [NUM_IOS-1:0] outputs_q, outputs_d;
    logic               ready_q, data_q, data_d, select_q, latch_q;

    logic               restart, pulse_en, phase;
    logic [CNT_W-1:0]   bit_cur, bit_nxt;
    logic [POS_W-1:0]   out_off, cap_off;

    scan_phase_gen #(.CNT_W(CNT_W)) u_phase_gen (
        .clk        (clk),
        .reset      (reset),
        .restart_i  (restart),
        .pulse_en_i (pulse_en),
        .bit_o      (bit_cur),
        .bit_nxt_o  (bit_nxt),
        .phase_o    (phase),
        .scan_clk_o (scan_clk)
    );

    // Scan bit k addresses chain position L-1-k.
    function automatic logic [POS_W-1:0] chain_pos(input logic [CNT_W-1:0] k);
        return POS_W'(LAST_BIT) - POS_W'(k);
    endfunction

`ifndef SCAN_SELECT_RANGE_CHECK_EN
    logic unused_sel;
    assign unused_sel = ^active_select[8:SEL_W];
`endif

    // Frame parameters are taken only when leaving IDLE.
    always_comb begin
        in_d    = in_q;
        base_d  = base_q;
        valid_d = valid_q;
        if (state_q == ST_IDLE) begin
            in_d = inputs;
`ifdef SCAN_SELECT_RANGE_CHECK_EN
            valid_d = (32'(active_select) < 32'(NUM_DESIGNS));
            base_d  = POS_W'(active_select) * POS_W'(NUM_IOS);
`else
            valid_d = 1'b1;
            base_d  = POS_W'(active_select[SEL_W-1:0]) * POS_W'(NUM_IOS);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      state_d = ST_SHIFT_IN;
            ST_SHIFT_IN:  if (phase && bit_cur == LAST_BIT) state_d = ST_LATCH;
            ST_LATCH:     if (phase) state_d = ST_CAPTURE;
            ST_CAPTURE:   if (phase) state_d = ST_SHIFT_OUT;
            ST_SHIFT_OUT: if (phase && bit_cur == LAST_BIT) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        restart  = (state_d != state_q);
        pulse_en = (state_q == ST_SHIFT_IN) || (state_q == ST_CAPTURE) ||
                   (state_q == ST_SHIFT_OUT);

        // Offsets wrap to large values below the active slot, so one compare bounds both sides.
        out_off = chain_pos(bit_nxt) - base_d;
        data_d  = 1'b0;
        if (state_d == ST_SHIFT_IN && valid_d && out_off < POS_W'(NUM_IOS))
            data_d = in_d[out_off[IO_W-1:0]];

        cap_off  = chain_pos(bit_cur) - base_q;
        shadow_d = shadow_q;
        if (state_q == ST_IDLE)
            shadow_d = '0;
        else if (state_q == ST_SHIFT_OUT && !phase && valid_q && cap_off < POS_W'(NUM_IOS))
            shadow_d[cap_off[IO_W-1:0]] = scan_data_in;

        outputs_d = (state_d == ST_DONE) ? shadow_q : outputs_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            in_q      <= '0;
            base_q    <= '0;
            valid_q   <= 1'b0;
            shadow_q  <= '0;
            outputs_q <= '0;
            ready_q   <= 1'b0;
            data_q    <= 1'b0;
            select_q  <= 1'b0;
            latch_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_q      <= in_d;
            base_q    <= base_d;
            valid_q   <= valid_d;
            shadow_q  <= shadow_d;
            outputs_q <= outputs_d;
            ready_q   <= (state_d == ST_DONE);
            data_q    <= data_d;
            select_q  <= (state_d == ST_CAPTURE);
            latch_q   <= (state_d == ST_LATCH);
        end
    end

    assign outputs           = outputs_q;
    assign ready             = ready_q;
    assign scan_data_out     = data_q;
    assign scan_select       = select_q;
    assign scan_latch_enable = latch_q;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Randomized scoreboard bench: four pass-through wrappers modelled as a bit array.
module tb_scan_chain_controller;

    localparam int ND    = 4;
    localparam int NI    = 8;
    localparam int L     = ND * NI;
    localparam int FRAME = 4 * L + 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [8:0]    active_select;
    logic [NI-1:0] inputs;
    logic [NI-1:0] outputs;
    logic          ready, scan_clk, scan_data_out, scan_data_in;
    logic          scan_select, scan_latch_enable;

    always #5 clk = ~clk;

    scan_chain_controller #(.NUM_DESIGNS(ND), .NUM_IOS(NI)) dut (
        .clk               (clk),
        .reset             (reset),
        .active_select     (active_select),
        .inputs            (inputs),
        .outputs           (outputs),
        .ready             (ready),
        .scan_clk          (scan_clk),
        .scan_data_out     (scan_data_out),
        .scan_data_in      (scan_data_in),
        .scan_select       (scan_select),
        .scan_latch_enable (scan_latch_enable)
    );

    // Wrapper chain: position p is design p/NI bit p%NI; each design echoes its latched inputs.
    logic          chain [L];
    logic [NI-1:0] dsg_in [ND];

    always @(posedge scan_clk) begin
        if (scan_select) begin
            for (int p = 0; p < L; p++) chain[p] <= dsg_in[p / NI][p % NI];
        end else begin
            chain[0] <= scan_data_out;
            for (int p = 1; p < L; p++) chain[p] <= chain[p - 1];
        end
    end

    always @(posedge scan_latch_enable) begin
        for (int p = 0; p < L; p++) dsg_in[p / NI][p % NI] <= chain[p];
    end

    assign scan_data_in = chain[L - 1];

    typedef struct {
        logic [NI-1:0] out;
        int            act;
        logic [NI-1:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc;
    int   last_rdy = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Which design a select value reaches, or -1 for none.
    function automatic int exp_act(input int sel);
`ifdef SCAN_SELECT_RANGE_CHECK_EN
        return (sel < ND) ? sel : -1;
`else
        return sel % ND;
`endif
    endfunction

    task automatic apply(input int sel, input logic [NI-1:0] val);
        exp_t e;
        active_select = 9'(sel);
        inputs        = val;
        e.act = exp_act(sel);
        e.val = val;
        e.out = (e.act >= 0) ? val : '0;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < FRAME + 20; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: no ready within %0d cycles", FRAME + 20);
        end
    endtask

    // Applies a frame from the DONE cycle; optionally scrambles inputs during SHIFT_IN.
    task automatic run_frame(input int sel, input logic [NI-1:0] val, input bit scramble);
        apply(sel, val);
        repeat (30) @(negedge clk);
        if (scramble) begin
            inputs        = NI'($urandom);
            active_select = 9'($urandom_range(0, 511));
        end
        wait_ready();
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 1;
        else       cyc <= cyc + 1;
    end

    // Monitor: every ready pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (reset) begin
            last_rdy = 0;
        end else if (ready) begin
            check("ready_period", 32'(cyc - last_rdy), 32'(FRAME));
            last_rdy = cyc;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ready: outputs %0h with empty scoreboard", outputs);
            end else begin
                mon_e = sb.pop_front();
                check("outputs", 32'(outputs), 32'(mon_e.out));
                for (int d = 0; d < ND; d++)
                    check($sformatf("design%0d_latched", d), 32'(dsg_in[d]),
                          32'((d == mon_e.act) ? mon_e.val : '0));
            end
        end
    end

    initial begin
        active_select = '0;
        inputs        = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(outputs), 32'h0);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_scan_clk", 32'(scan_clk), 32'h0);
        check("reset_data_out", 32'(scan_data_out), 32'h0);
        check("reset_select", 32'(scan_select), 32'h0);
        check("reset_latch", 32'(scan_latch_enable), 32'h0);

        apply(0, 8'hA5);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        inputs = 8'h5F;
        wait_ready();

        run_frame(3, 8'h3C, 1'b1);
        apply(0, 8'h11);
        repeat (30) @(negedge clk);
        inputs = 8'h22;
        wait_ready();
        run_frame(0, 8'h22, 1'b0);
        run_frame(5, 8'h5A, 1'b1);

        for (int i = 0; i < 8; i++)
            run_frame(int'($urandom_range(0, 511)), NI'($urandom), 1'b1);

        run_frame(1, 8'h96, 1'b1);
        apply(2, 8'hC3);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_outputs", 32'(outputs), 32'h0);
        check("abort_ready", 32'(ready), 32'h0);
        check("abort_scan_clk", 32'(scan_clk), 32'h0);
        check("abort_data_out", 32'(scan_data_out), 32'h0);
        check("abort_select", 32'(scan_select), 32'h0);
        check("abort_latch", 32'(scan_latch_enable), 32'h0);
        sb.delete();
        repeat (3) @(negedge clk);
        apply(2, 8'h4B);
        reset = 1'b0;
        wait_ready();

        run_frame(int'($urandom_range(0, 511)), NI'($urandom), 1'b1);

        @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
